// File: rtl/switch_operand_debouncer.sv
// ----------------------------------------------------------------------------
// switch_operand_debouncer
//   Input front end for the gate-level comparator. The raw slide-switch pads
//   (pulled up, asynchronous) are synchronised into the clk domain, decoded
//   and debounced as one combined word. A new operand pair is committed only
//   after the decoded word has stayed unchanged for DEBOUNCE_CYCLES cycles.
//   A one-cycle upd_o strobe marks every edge on which a_o/b_o change.
//
// Ports
//   clk     in   1      system clock
//   rst_n   in   1      synchronous active-low reset
//   sw1     in   WIDTH  raw switch pads, operand A (pulled up)
//   sw2     in   WIDTH  raw switch pads, operand B (pulled up)
//   a_o     out  WIDTH  committed operand A
//   b_o     out  WIDTH  committed operand B
//   upd_o   out  1      one-cycle pulse, a_o/b_o changed on this edge
//   busy_o  out  1      high while a candidate value is settling
// ----------------------------------------------------------------------------

// Single-bit synchroniser chain. Resets to 1 so an idle pulled-up pad never
// looks like a switch event coming out of reset.
module switch_operand_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sync_pipe;

   always_ff @(posedge clk) begin
      if (!rst_n) sync_pipe <= '1;
      else        sync_pipe <= {sync_pipe[STAGES-2:0], d};
   end

   assign q = sync_pipe[STAGES-1];
endmodule

module switch_operand_debouncer #(
   parameter int WIDTH           = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 240000,
   parameter bit INVERT          = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw1,
   input  logic [WIDTH-1:0] sw2,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             upd_o,
   output logic             busy_o
);
   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_t;

   logic [PW-1:0]    pads, raw, dec;
   state_t           state, state_nxt;
   logic [PW-1:0]    cand, cand_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             settle_done;
   logic [PW-1:0]    op_q, op_nxt;
   logic             upd_nxt, busy_nxt, commit;

   // Pads go straight into the first flop; decode happens after the chain.
   assign pads = {sw1, sw2};

   for (genvar g = 0; g < PW; g++) begin : g_sync
      switch_operand_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (pads[g]),
         .q     (raw[g])
      );
   end

   assign dec = INVERT ? ~raw : raw;

   // State register: FSM, candidate, counter and the registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         cand   <= '0;
         cnt    <= '0;
         op_q   <= '0;
         upd_o  <= 1'b0;
         busy_o <= 1'b0;
      end else begin
         state  <= state_nxt;
         cand   <= cand_nxt;
         cnt    <= cnt_nxt;
         op_q   <= op_nxt;
         upd_o  <= upd_nxt;
         busy_o <= busy_nxt;
      end
   end

   // Next state. Any change of the decoded word reloads the candidate and
   // restarts the count, so staggered bit changes collapse into one event.
   always_comb begin
      state_nxt   = state;
      cand_nxt    = cand;
      cnt_nxt     = cnt;
      settle_done = 1'b0;
      case (state)
         IDLE: begin
            if (dec != cand) begin
               cand_nxt  = dec;
               cnt_nxt   = '0;
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (dec != cand) begin
               cand_nxt = dec;
               cnt_nxt  = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt   = IDLE;
               settle_done = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;   // bounded by CNT_LAST, never wraps
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode. A settled candidate equal to the committed pair (a glitch
   // that returned) produces no strobe and leaves the outputs alone.
   always_comb begin
      commit   = settle_done && (cand != op_q);
      op_nxt   = commit ? cand : op_q;
      upd_nxt  = commit;
      busy_nxt = (state_nxt == SETTLE);
   end

   assign {a_o, b_o} = op_q;
endmodule

// File: tb/tb_switch_operand_debouncer.sv
module tb_switch_operand_debouncer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] sw1, sw2;
   logic [1:0] a_o, b_o;
   logic       upd_o, busy_o;

   int n_chk = 0;
   int n_err = 0;
   int nb;

   switch_operand_debouncer #(
      .WIDTH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .INVERT(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sw1(sw1), .sw2(sw2),
      .a_o(a_o), .b_o(b_o), .upd_o(upd_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one edge; inputs are driven and outputs sampled 1 ns later.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Run n edges. Commit expected on edge cedge (1-based, 0 = none): upd_o is
   // high only there, a/b hold the old pair before it and the new one after.
   task automatic run_expect(input string tag, input int n, input int cedge,
                             input logic [1:0] a0, input logic [1:0] b0,
                             input logic [1:0] a1, input logic [1:0] b1,
                             output int nbusy);
      nbusy = 0;
      for (int i = 1; i <= n; i++) begin
         tick();
         if (busy_o) nbusy++;
         check({tag, "_upd"}, upd_o, (i == cedge));
         check({tag, "_a"}, a_o, (cedge != 0 && i >= cedge) ? a1 : a0);
         check({tag, "_b"}, b_o, (cedge != 0 && i >= cedge) ? b1 : b0);
      end
   endtask

   initial begin
      // 1: reset with pads idle high
      rst_n = 1'b0; sw1 = 2'b11; sw2 = 2'b11;
      repeat (3) tick();
      check("rst_a", a_o, 2'b00);
      check("rst_b", b_o, 2'b00);
      check("rst_upd", upd_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      rst_n = 1'b1;
      run_expect("idle", 5, 0, 2'b00, 2'b00, 2'b00, 2'b00, nb);
      check("idle_busy", nb, 0);

      // 2: sw1 -> 10, commit a=01 seven edges after pad change
      sw1 = 2'b10;
      run_expect("t2", 8, 7, 2'b00, 2'b00, 2'b01, 2'b00, nb);
      check("t2_busy", nb, 4);

      // 3: sw2[0] bounces every 2 cycles for 20 cycles, then settles low
      for (int t = 0; t < 20; t++) begin
         sw2 = {1'b1, ((t / 2) % 2) == 1};
         tick();
         if (t >= 2) check("t3_busy_hold", busy_o, 1'b1);
         check("t3_upd_hold", upd_o, 1'b0);
         check("t3_b_hold", b_o, 2'b00);
      end
      sw2 = 2'b10;
      run_expect("t3", 8, 7, 2'b01, 2'b00, 2'b01, 2'b01, nb);
      check("t3_busy", nb, 6);

      // 4: one-cycle low glitch on sw1[1]
      sw1 = 2'b00;
      tick();
      check("t4_busy0", busy_o, 1'b0);
      sw1 = 2'b10;
      run_expect("t4", 9, 0, 2'b01, 2'b01, 2'b01, 2'b01, nb);
      check("t4_busy", nb, 5);

      // 5: reset in SETTLE with cnt=2
      sw1 = 2'b01;
      repeat (5) tick();
      check("t5_busy_pre", busy_o, 1'b1);
      check("t5_cnt_pre", dut.cnt, 2);
      rst_n = 1'b0;
      tick();
      check("t5_rst_a", a_o, 2'b00);
      check("t5_rst_b", b_o, 2'b00);
      check("t5_rst_busy", busy_o, 1'b0);
      rst_n = 1'b1;
      run_expect("t5", 8, 7, 2'b00, 2'b00, 2'b10, 2'b01, nb);
      check("t5_busy", nb, 4);

      // 6: two operands change one cycle apart -> single commit
      sw1 = 2'b00;
      tick();
      check("t6_upd0", upd_o, 1'b0);
      sw2 = 2'b01;
      run_expect("t6", 10, 7, 2'b10, 2'b01, 2'b11, 2'b10, nb);
      check("t6_busy", nb, 5);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
